// File: rtl/link_partner.sv
// ---------------------------------------------------------------------------
// link_partner
//
// Model of the device at the far end of the link cable, the counterpart to
// the DMG serial port. Each transfer exchanges one byte over SCK/SOUT/SIN,
// MSB first. In slave mode the block follows the SCK driven by the DMG. In
// master mode it drives SCK itself, with DIV system clocks per half-period.
//
// Parameters:
//   DIV      system clocks per SCK half-period in master mode (>= 4)
//
// Ports:
//   clk      system clock, every flop is rising-edge
//   nreset   asynchronous active-low reset
//   sck_in   SCK pin as driven by the DMG (asynchronous)
//   sck_out  SCK level driven in master mode
//   sck_oe   SCK output enable, high only during a master transfer
//   sout     DMG SOUT pin (asynchronous)
//   sin      data driven onto the DMG SIN pin
//   tx_data  byte to send
//   tx_load  one-cycle strobe that starts a transfer when idle
//   master   mode select, latched on an accepted tx_load (1 = master)
//   abort    cancels the current transfer, no done pulse
//   busy     transfer in progress
//   done     one-cycle pulse on completion
//   rx_data  last received byte, held until the next completion
// ---------------------------------------------------------------------------
module link_partner #(
    parameter int DIV = 512
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       sck_in,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic       sout,
    output logic       sin,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    input  logic       master,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);

    localparam int             DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LOAD = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLAVE  = 2'd1,
        ST_MASTER = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           sck_s1_q, sck_s1_d;
    logic           sck_s2_q, sck_s2_d;
    logic           sck_s3_q, sck_s3_d;
    logic           sout_s1_q, sout_s1_d;
    logic           sout_s2_q, sout_s2_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [DW-1:0]  div_q, div_d;
    logic           sck_out_q, sck_out_d;
    logic           sck_oe_q, sck_oe_d;
    logic           sin_q, sin_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     rx_q, rx_d;

    logic           slv_rise;
    logic           slv_fall;
    logic           div_zero;
    logic           m_rise;
    logic           m_fall;
    logic           shift_edge;
    logic           fall_edge;
    logic [7:0]     shifted;

    // Edge detection compares the synchronized SCK with one further delayed
    // copy, so a pin edge acts three clk edges after it happens.
    always_comb begin
        slv_rise   = (state_q == ST_SLAVE) && sck_s2_q && !sck_s3_q;
        slv_fall   = (state_q == ST_SLAVE) && !sck_s2_q && sck_s3_q;
        div_zero   = (div_q == '0);
        m_rise     = (state_q == ST_MASTER) && div_zero && !sck_out_q;
        m_fall     = (state_q == ST_MASTER) && div_zero && sck_out_q;
        shift_edge = slv_rise || m_rise;
        fall_edge  = slv_fall || m_fall;
        shifted    = {shreg_q[6:0], sout_s2_q};
    end

    // Next-state logic. Abort has priority over everything in a busy state
    // and also suppresses a load in the idle state.
    always_comb begin
        state_d   = state_q;
        sck_s1_d  = sck_in;
        sck_s2_d  = sck_s1_q;
        sck_s3_d  = sck_s2_q;
        sout_s1_d = sout;
        sout_s2_d = sout_s1_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sck_out_d = sck_out_q;
        sck_oe_d  = sck_oe_q;
        sin_d     = sin_q;
        done_d    = 1'b0;
        rx_d      = rx_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_load && !abort) begin
                    shreg_d = tx_data;
                    sin_d   = tx_data[7];
                    cnt_d   = 3'd0;
                    if (master) begin
                        state_d   = ST_MASTER;
                        div_d     = DIV_LOAD;
                        sck_out_d = 1'b1;
                        sck_oe_d  = 1'b1;
                    end else begin
                        state_d = ST_SLAVE;
                    end
                end
            end

            ST_SLAVE, ST_MASTER: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    sck_oe_d  = 1'b0;
                    sck_out_d = 1'b1;
                    cnt_d     = 3'd0;
                end else begin
                    if (state_q == ST_MASTER) begin
                        if (div_zero) begin
                            div_d     = DIV_LOAD;
                            sck_out_d = !sck_out_q;
                        end else begin
                            div_d = div_q - DW'(1);
                        end
                    end

                    if (fall_edge) begin
                        sin_d = shreg_q[7];
                    end

                    // The 8th rising edge is seen as count==7, so the
                    // counter never wraps while busy.
                    if (shift_edge) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_d      = shifted;
                            done_d    = 1'b1;
                            state_d   = ST_IDLE;
                            sck_oe_d  = 1'b0;
                            sck_out_d = 1'b1;
                            cnt_d     = 3'd0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            sck_s1_q  <= 1'b1;
            sck_s2_q  <= 1'b1;
            sck_s3_q  <= 1'b1;
            sout_s1_q <= 1'b1;
            sout_s2_q <= 1'b1;
            shreg_q   <= 8'hFF;
            cnt_q     <= 3'd0;
            div_q     <= '0;
            sck_out_q <= 1'b1;
            sck_oe_q  <= 1'b0;
            sin_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_q      <= 8'hFF;
        end else begin
            state_q   <= state_d;
            sck_s1_q  <= sck_s1_d;
            sck_s2_q  <= sck_s2_d;
            sck_s3_q  <= sck_s3_d;
            sout_s1_q <= sout_s1_d;
            sout_s2_q <= sout_s2_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sck_out_q <= sck_out_d;
            sck_oe_q  <= sck_oe_d;
            sin_q     <= sin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_q      <= rx_d;
        end
    end

    assign sck_out = sck_out_q;
    assign sck_oe  = sck_oe_q;
    assign sin     = sin_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule
